// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences the shared ALU/memory datapath,
// with memory wait handshake, jumps, immediate ops, trap and retire count.
module multicycle_control #(
  parameter int CNT_W       = 16,
  parameter bit ENABLE_IMM  = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OPCODE,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdist,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  state_t cur, nxt;
  logic   is_r, is_lw, is_sw, is_beq, is_j, is_imm;
  logic   retire;

  assign is_r   = (OPCODE == OP_R);
  assign is_lw  = (OPCODE == OP_LW);
  assign is_sw  = (OPCODE == OP_SW);
  assign is_beq = (OPCODE == OP_BEQ);
  assign is_j   = (OPCODE == OP_J);
  assign is_imm = (OPCODE == OP_ADDI) | (OPCODE == OP_ANDI)
                | (OPCODE == OP_ORI)  | (OPCODE == OP_SLTI);

  // only completing states can fall back to FETCH
  assign retire = (cur != S_FETCH) && (nxt == S_FETCH);
  assign state  = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= S_FETCH;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      cur <= nxt;
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
      if (nxt == S_TRAP)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw | is_sw:             nxt = S_MEMADR;
          is_r:                      nxt = S_RTEX;
          is_beq:                    nxt = S_BEQ;
          is_imm && ENABLE_IMM:      nxt = S_IMMEX;
          is_j && ENABLE_JUMP:       nxt = S_JUMP;
          default:                   nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        unique case (1'b1)
          is_lw:   nxt = S_MEMRD;
          is_sw:   nxt = S_MEMWR;
          default: nxt = S_TRAP;
        endcase
      end
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_RTEX:   nxt = S_RTWB;
      S_RTWB:   nxt = S_FETCH;
      S_BEQ:    nxt = S_FETCH;
      S_IMMEX:  nxt = S_IMMWB;
      S_IMMWB:  nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      default:  nxt = S_TRAP;
    endcase
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdist     = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 3'b000;
    pcsource    = 2'b00;
    case (cur)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluop   = 3'b010;
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdist  = 1'b1;
      end
      S_BEQ: begin
        alusrca     = 1'b1;
        aluop       = 3'b001;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        unique case (1'b1)
          OPCODE == OP_ANDI: aluop = 3'b011;
          OPCODE == OP_ORI:  aluop = 3'b100;
          OPCODE == OP_SLTI: aluop = 3'b101;
          default:           aluop = 3'b000;
        endcase
      end
      S_IMMWB:  regwrite = 1'b1;
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control, plus directed
// reset-abort, counter-wrap and trap checks on a reduced instance.
module tb_multicycle_control;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010;

  logic clk = 1'b0;
  logic rst_n, mr;
  logic [5:0] op;
  logic pw, pwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, ill;
  logic [1:0] asb, psrc;
  logic [2:0] aop;
  logic [3:0] st;
  logic [15:0] cnt;

  logic rst1_n, mr1;
  logic [5:0] op1;
  logic pw1, pwc1, iord1, mrd1, mwr1, irw1, m2r1, rd1, rw1, asa1, ill1;
  logic [1:0] asb1, psrc1;
  logic [2:0] aop1;
  logic [3:0] st1;
  logic [3:0] cnt1;

  int ncmp = 0;
  int nbad = 0;

  typedef struct {
    int          st;
    bit          mr;
    logic [5:0]  op;
    logic [15:0] cnt;
  } exp_t;
  exp_t sbq[$];
  logic [15:0] mcnt = '0;

  always #5 clk = ~clk;

  multicycle_control u0 (
    .clk(clk), .rst_n(rst_n), .OPCODE(op), .mem_ready(mr),
    .pcwrite(pw), .pcwritecond(pwc), .iord(iord), .memread(mrd),
    .memwrite(mwr), .irwrite(irw), .memtoreg(m2r), .regdist(rd),
    .regwrite(rw), .alusrca(asa), .alusrcb(asb), .aluop(aop),
    .pcsource(psrc), .illegal(ill), .state(st), .instr_count(cnt)
  );

  multicycle_control #(.CNT_W(4), .ENABLE_IMM(1'b0), .ENABLE_JUMP(1'b1)) u1 (
    .clk(clk), .rst_n(rst1_n), .OPCODE(op1), .mem_ready(mr1),
    .pcwrite(pw1), .pcwritecond(pwc1), .iord(iord1), .memread(mrd1),
    .memwrite(mwr1), .irwrite(irw1), .memtoreg(m2r1), .regdist(rd1),
    .regwrite(rw1), .alusrca(asa1), .alusrcb(asb1), .aluop(aop1),
    .pcsource(psrc1), .illegal(ill1), .state(st1), .instr_count(cnt1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // control word for a state, straight from the per-state output table
  function automatic logic [16:0] exp_ctl(int s, bit m, logic [5:0] o);
    logic e_pw, e_pwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rd, e_rw, e_asa;
    logic [1:0] e_asb, e_psrc;
    logic [2:0] e_aop;
    {e_pw, e_pwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rd, e_rw, e_asa} = '0;
    e_asb = 2'd0;
    e_psrc = 2'd0;
    e_aop = 3'd0;
    case (s)
      0: begin e_mrd = 1; e_asb = 2'd1; e_irw = m; e_pw = m; end
      1: e_asb = 2'd3;
      2: begin e_asa = 1; e_asb = 2'd2; end
      3: begin e_iord = 1; e_mrd = 1; end
      4: begin e_rw = 1; e_m2r = 1; end
      5: begin e_iord = 1; e_mwr = 1; end
      6: begin e_asa = 1; e_aop = 3'd2; end
      7: begin e_rw = 1; e_rd = 1; end
      8: begin e_asa = 1; e_aop = 3'd1; e_pwc = 1; e_psrc = 2'd1; end
      9: begin
        e_asa = 1;
        e_asb = 2'd2;
        e_aop = (o == ANDI) ? 3'd3 : (o == ORI) ? 3'd4 :
                (o == SLTI) ? 3'd5 : 3'd0;
      end
      10: e_rw = 1;
      11: begin e_pw = 1; e_psrc = 2'd2; end
      default: ;
    endcase
    return {e_pw, e_pwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rd, e_rw,
            e_asa, e_asb, e_aop, e_psrc};
  endfunction

  function automatic logic [16:0] ctl0();
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  // one cycle of stimulus; its expected observation goes to the scoreboard
  task automatic step(input int s, input bit m, input logic [5:0] o);
    @(posedge clk);
    #1;
    mr = m;
    op = o;
    sbq.push_back('{s, m, o, mcnt});
  endtask

  task automatic issue(input logic [5:0] o, input int sf, input int sm);
    for (int i = 0; i <= sf; i++)
      step(0, i == sf, 6'($urandom));
    step(1, 1'($urandom), o);
    if (o == R) begin
      step(6, 1'($urandom), o);
      step(7, 1'($urandom), o);
    end else if (o == LW) begin
      step(2, 1'($urandom), o);
      for (int i = 0; i <= sm; i++) step(3, i == sm, o);
      step(4, 1'($urandom), o);
    end else if (o == SW) begin
      step(2, 1'($urandom), o);
      for (int i = 0; i <= sm; i++) step(5, i == sm, o);
    end else if (o == BEQ) begin
      step(8, 1'($urandom), o);
    end else if (o == J) begin
      step(11, 1'($urandom), o);
    end else begin
      step(9, 1'($urandom), o);
      step(10, 1'($urandom), o);
    end
    mcnt = mcnt + 16'd1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("state", int'(st), e.st);
        chk("ctl", int'(ctl0()), int'(exp_ctl(e.st, e.mr, e.op)));
        chk("count", int'(cnt), int'(e.cnt));
        chk("illegal", int'(ill), 0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [5:0] ops [9];
    ops = '{R, LW, SW, BEQ, J, ADDI, ANDI, ORI, SLTI};
    rst_n = 0; rst1_n = 0;
    mr = 0; mr1 = 0; op = R; op1 = J;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", int'(st), 0);
    chk("rst_count", int'(cnt), 0);
    chk("rst_illegal", int'(ill), 0);
    chk("rst_ctl", int'(ctl0()), int'(exp_ctl(0, 0, R)));
    rst_n = 1;

    issue(R, 0, 0);
    issue(LW, 2, 3);
    issue(BEQ, 0, 0);
    issue(ORI, 0, 0);
    issue(J, 1, 0);
    for (int n = 0; n < 80; n++)
      issue(ops[$urandom_range(0, 8)], $urandom_range(0, 2),
            $urandom_range(0, 3));

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    // abort a stalled store with an asynchronous reset
    @(posedge clk); #1 mr = 1; op = SW;
    @(posedge clk); #1 mr = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_state", int'(st), 5);
    chk("sw_memwrite", int'(mwr), 1);
    chk("sw_count", int'(cnt), int'(mcnt));
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("abort_memwrite", int'(mwr), 0);
    chk("abort_state", int'(st), 0);
    chk("abort_count", int'(cnt), 0);
    chk("abort_illegal", int'(ill), 0);
    chk("abort_memread", int'(mrd), 1);

    // reduced instance: 4-bit count wraps after 16 jumps
    mr1 = 1;
    op1 = J;
    @(negedge clk);
    rst1_n = 1;
    for (int n = 0; n < 16; n++) begin
      #1;
      chk("j_fetch", int'(st1), 0);
      chk("j_count", int'(cnt1), n);
      @(negedge clk);
      chk("j_decode", int'(st1), 1);
      @(negedge clk);
      chk("j_state", int'(st1), 11);
      chk("j_ctl", int'({pw1, psrc1}), 3'b110);
      @(negedge clk);
    end
    chk("wrap_state", int'(st1), 0);
    chk("wrap_count", int'(cnt1), 0);

    // immediate ops disabled on this instance: trap
    op1 = ORI;
    @(negedge clk);
    chk("ori_decode", int'(st1), 1);
    @(negedge clk);
    chk("trap_state", int'(st1), 12);
    chk("trap_illegal", int'(ill1), 1);
    for (int i = 0; i < 20; i++) begin
      mr1 = 1'($urandom);
      @(negedge clk);
      chk("trap_hold", int'({st1, ill1, cnt1}), int'({4'd12, 1'b1, 4'd0}));
      chk("trap_strobes",
          int'({pw1, pwc1, mrd1, mwr1, irw1, rw1}), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
